// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader sitting in front of the CPU datapath.
// It takes a framed byte stream (SYNC_BYTE, LEN_H, LEN_L, then LEN big-endian
// 16-bit words) and writes the words into the program RAM. The CPU is held in
// reset until a complete, valid image has been written.
// The program RAM is read combinationally by the CPU at all times.
// Optional build macro: PROG_LOADER_CHECKSUM_EN. When it is defined, a trailing
// checksum byte is expected after the last word. The load succeeds only if the
// 8-bit modular sum of the data bytes plus the checksum byte is zero.
module prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [15:0]       cpu_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        SYNC, LEN_H, LEN_L, DATA_H, DATA_L, CHK, RUN, ERROR
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [15:0]       lenReg;
    // One bit wider than the RAM address so that a full-depth image can be
    // compared against LEN without overflowing.
    logic [ADDR_W:0]   wordAddr;
    logic [7:0]        hiByte;
    logic              accept;
    logic [15:0]       lenNow;
    logic              lenBad;
    logic              lastWord;
    logic              memWe;
    logic [15:0]       mem [DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sumReg;
    logic [7:0]        chkSum;
`endif

    assign accept   = rx_valid && rx_ready;
    assign lenNow   = {lenReg[15:8], rx_data};
    // Every length bit counts toward the upper bound, not just the low ADDR_W+1.
    assign lenBad   = (lenNow == 16'd0) || (32'(lenNow) > DEPTH);
    assign lastWord = (32'(wordAddr) + 32'd1) == 32'(lenReg);
    // start wins over a coincident byte, so that byte must not reach the RAM.
    assign memWe    = accept && !start && (state == DATA_L);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign chkSum   = sumReg + rx_data;
`endif

    // The loader stops listening once it has finished, whether it succeeded or failed.
    always_comb begin
        rx_ready = 1'b1;
        if (state == RUN || state == ERROR) begin
            rx_ready = 1'b0;
        end
    end

    // Next-state logic: start overrides everything; otherwise advance on accepted bytes.
    always_comb begin
        stateNext = state;
        if (start) begin
            stateNext = SYNC;
        end else if (accept) begin
            case (state)
                SYNC:    if (rx_data == SYNC_BYTE) stateNext = LEN_H;
                LEN_H:   stateNext = LEN_L;
                LEN_L:   stateNext = lenBad ? ERROR : DATA_H;
                DATA_H:  stateNext = DATA_L;
                DATA_L: begin
                    if (lastWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        stateNext = CHK;
`else
                        stateNext = RUN;
`endif
                    end else begin
                        stateNext = DATA_H;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK:     stateNext = (chkSum == 8'd0) ? RUN : ERROR;
`else
                CHK:     stateNext = ERROR;
`endif
                default: stateNext = state;
            endcase
        end
    end

    // State register, with the status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= stateNext;
            cpu_reset <= (stateNext != RUN);
            done      <= (stateNext == RUN);
            error     <= (stateNext == ERROR);
        end
    end

    // Length, word address, high-byte holding register and (optionally) the running sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lenReg   <= '0;
            wordAddr <= '0;
            hiByte   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sumReg   <= '0;
`endif
        end else if (start) begin
            lenReg   <= '0;
            wordAddr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sumReg   <= '0;
`endif
        end else if (accept) begin
            case (state)
                LEN_H: lenReg[15:8] <= rx_data;
                LEN_L: begin
                    lenReg[7:0] <= rx_data;
                    wordAddr    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sumReg      <= '0;
`endif
                end
                DATA_H: begin
                    hiByte <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sumReg <= sumReg + rx_data;
`endif
                end
                DATA_L: begin
                    wordAddr <= wordAddr + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sumReg   <= sumReg + rx_data;
`endif
                end
                default: ;
            endcase
        end
    end

    // Program RAM write port. The contents survive reset, so a partial image can
    // remain after an aborted load.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[wordAddr[ADDR_W-1:0]] <= {hiByte, rx_data};
        end
    end

    assign cpu_data = mem[cpu_addr];

endmodule

// File: doc/prog_loader.md
Name:
prog_loader

Overview:
- Boot-time program loader upstream of the CPU datapath; owns the program RAM that drives the datapath's programData.
- Receives a framed byte stream (e.g. from a UART receiver) and assembles big-endian 16-bit instruction words.
- Writes the words into program RAM and holds the CPU in reset until a complete, valid image is loaded.
- Serves combinational instruction reads to the CPU at all times.

Parameters:
- ADDR_W, 10, program address width; RAM depth 2^ADDR_W words; legal range 1..16.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- start  in  1  single-cycle pulse; restarts the load sequence
- cpu_addr  in  ADDR_W  instruction fetch address (CPU programAddress)
- cpu_data  out  16  instruction word, RAM[cpu_addr], combinational read
- cpu_reset  out  1  reset to the CPU, active-high
- done  out  1  image loaded, CPU running
- error  out  1  load failed

Behaviour:
- Byte transfer occurs on a rising clk edge with rx_valid=1 and rx_ready=1. rx_valid without rx_ready is not consumed; the source holds the byte.
- Reset (async) sets: state=SYNC, cpu_reset=1, done=0, error=0, rx_ready=1 (combinational from state), word counter=0, length=0. RAM contents are not cleared.
- Frame format: SYNC_BYTE, LEN_H, LEN_L, then LEN words as hi byte then lo byte, then [checksum byte, only with the optional feature].
- States and transitions:
  - SYNC: SYNC_BYTE goes to LEN_H; any other byte is discarded and the state stays SYNC.
  - LEN_H: latch the length high byte; go to LEN_L.
  - LEN_L: latch the length low byte. If LEN==0 or LEN>2^ADDR_W, go to ERROR; otherwise go to DATA_H with word addr=0.
  - DATA_H: latch the hi byte; go to DATA_L.
  - DATA_L: write {hi,lo} to RAM[addr] on the same edge; increment addr. If addr+1==LEN, go to CHK (feature on) or RUN (feature off); otherwise go to DATA_H.
  - CHK: compare the checksum; match goes to RUN, mismatch goes to ERROR.
  - RUN: cpu_reset=0, done=1, rx_ready=0.
  - ERROR: error=1, cpu_reset=1, rx_ready=0.
- rx_ready=1 in SYNC, LEN_H, LEN_L, DATA_H, DATA_L and CHK.
- cpu_reset is registered and deasserts on the edge that enters RUN. done and error are registered and follow the state.
- Write-to-read latency: a word written at edge N is visible on cpu_data after edge N when cpu_addr matches.
- cpu_data is always RAM[cpu_addr], in every state.
- LEN=2^ADDR_W: the address counter wraps to 0 after the last write, which is legal. The counter is ADDR_W+1 bits internally for the compare.
- start in any state: go to SYNC, cpu_reset=1, done=0, error=0, counters cleared.
- start coincident with a byte handshake: start wins; the byte is dropped (it counts as consumed, since rx_ready was 1).
- Reset mid-load: same as power-on reset. The partial image remains in RAM, but the CPU stays in reset.
- Upper length bits beyond ADDR_W+1 count toward the >2^ADDR_W check.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Running 8-bit modular sum of every data byte (DATA_H/DATA_L), cleared in LEN_L.
  - A CHK state accepts one trailing byte; (sum + byte) mod 256 == 0 goes to RUN, else ERROR.
- Undefined:
  - No CHK state; DATA_L goes to RUN after the last word.
  - No checksum byte is expected; a trailing byte sees rx_ready=0.

Test Plan:
1. Reset; bytes A5 00 02 12 34 AB CD [+42 with checksum] -> RAM[0]=0x1234, RAM[1]=0xABCD, done=1, cpu_reset=0 one edge after the final byte; cpu_addr=1 gives cpu_data=0xABCD.
2. Bytes 00 FF 5A then the frame from test 1 -> leading bytes ignored; same result as test 1.
3. A5 00 00 -> error=1, cpu_reset=1, rx_ready=0. With ADDR_W=10, A5 04 01 -> error; A5 04 00 plus 1024 words -> done, and the last word lands in RAM[1023].
4. rx_valid with random gaps (0-5 idle cycles) during test 1; in RUN, rx_valid=1 with byte 77 -> identical RAM image, and 77 is not consumed (rx_ready=0).
5. start pulse after A5 00 03 11 22 -> state SYNC, done=0, cpu_reset=1. A subsequent full frame with LEN=1 word BEEF writes RAM[0]=0xBEEF. Repeat the abort using async reset mid-DATA_L -> same outcome.
6. PROG_LOADER_CHECKSUM_EN defined; frame from test 1 with checksum 43 -> error=1, cpu_reset=1. Then start plus the correct frame -> done=1, error=0.
